vga_timing_gen: RTL and testbench

Generates 640x480@60 Hz VGA raster timing from the 50 MHz system clock. Produces the pixel strobe, `hCount`/`vCount`, `bright`, and active-low `hSync`/`vSync`, plus a per-frame `frame_start` pulse and a `vblank` level. Sits directly upstream of the sprite renderer (`vgaFSM`), which consumes `hCount`/`vCount`/`bright` and registers RGB one clock later. `frame_start` lets the renderer re-arm its BRAM position load once per frame.

---
 rtl/vga_pkg.sv | 31 +++
 rtl/vga_pix_strobe.sv | 31 +++
 rtl/vga_timing_gen.sv | 104 ++++++++++
 tb/tb_vga_timing_gen.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants, coordinate type and decode helper.
package vga_pkg;

    localparam int COORD_W   = 10;

    localparam int H_VISIBLE_DEF = 640;
    localparam int H_FP_DEF      = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BP_DEF      = 48;
    localparam int H_TOTAL_DEF   = H_VISIBLE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;  // 800

    localparam int V_VISIBLE_DEF = 480;
    localparam int V_FP_DEF      = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BP_DEF      = 33;
    localparam int V_TOTAL_DEF   = V_VISIBLE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;  // 525

    // Sync windows are [start, end): 656..751 and 490..491.
    localparam int H_SYNC_START_DEF = H_VISIBLE_DEF + H_FP_DEF;                      // 656
    localparam int H_SYNC_END_DEF   = H_SYNC_START_DEF + H_SYNC_DEF;                 // 752
    localparam int V_SYNC_START_DEF = V_VISIBLE_DEF + V_FP_DEF;                      // 490
    localparam int V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_DEF;                 // 492

    typedef logic [COORD_W-1:0] coord_t;

    // True when lo <= c < hi.
    function automatic logic in_range(coord_t c, int lo, int hi);
        return (int'(c) >= lo) && (int'(c) < hi);
    endfunction

endpackage

// File: rtl/vga_pix_strobe.sv
// Pixel-rate strobe: divides clk by CLK_DIV and emits a registered one-clk pix_en.
module vga_pix_strobe #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    output logic pix_en
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div;

    // Divider counts 0..CLK_DIV-1; pix_en follows the clk where div sits at its last value.
    always_ff @(posedge clk) begin
        // NOTE: synchronous active-low reset; every state bit here is a flop, so all get a reset value.
        if (!reset) begin
            div    <= '0;
            pix_en <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so pix_en samples the old div, not the updated one.
            pix_en <= (div == DIV_LAST);
            if (div == DIV_LAST)
                div <= '0;
            else
                div <= div + DIV_W'(1);
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel strobe, counters, and registered decode.
// Optional macro VGA_SYNC_ALIGN_EN adds one clk of delay on hSync/vSync only,
// lining them up with the renderer's registered RGB.
// H and V totals must each be <= 1024 to fit the 10-bit coordinates.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int CLK_DIV   = 2,
    parameter int H_VISIBLE = H_VISIBLE_DEF,
    parameter int H_FP      = H_FP_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BP      = H_BP_DEF,
    parameter int V_VISIBLE = V_VISIBLE_DEF,
    parameter int V_FP      = V_FP_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BP      = V_BP_DEF
) (
    input  logic               clk,
    input  logic               reset,
    output logic               pix_en,
    output logic [COORD_W-1:0] hCount,
    output logic [COORD_W-1:0] vCount,
    output logic               bright,
    output logic               hSync,
    output logic               vSync,
    output logic               vblank,
    output logic               frame_start
);

    localparam int H_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_VISIBLE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_VISIBLE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    coord_t h_next;
    coord_t v_next;
    logic   h_sync_dec;
    logic   v_sync_dec;

    vga_pix_strobe #(.CLK_DIV(CLK_DIV)) u_strobe (
        .clk    (clk),
        .reset  (reset),
        .pix_en (pix_en)
    );

    // Next-state counter values; hold between strobes, wrap at line and frame end.
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        h_next = hCount;
        v_next = vCount;
        if (pix_en) begin
            if (hCount == coord_t'(H_TOTAL - 1)) begin
                h_next = '0;
                if (vCount == coord_t'(V_TOTAL - 1))
                    v_next = '0;
                else
                    v_next = vCount + coord_t'(1);
            end else begin
                h_next = hCount + coord_t'(1);
            end
        end
    end

    // Counters plus outputs decoded from next-state values, so they line up with the counters.
    always_ff @(posedge clk) begin
        if (!reset) begin
            hCount      <= '0;
            vCount      <= '0;
            bright      <= 1'b0;
            h_sync_dec  <= 1'b1;
            v_sync_dec  <= 1'b1;
            vblank      <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            hCount      <= h_next;
            vCount      <= v_next;
            bright      <= in_range(h_next, 0, H_VISIBLE) && in_range(v_next, 0, V_VISIBLE);
            h_sync_dec  <= !in_range(h_next, HS_START, HS_END);
            v_sync_dec  <= !in_range(v_next, VS_START, VS_END);
            vblank      <= !in_range(v_next, 0, V_VISIBLE);
            // Only a real wrap into (0,0) pulses; reset release does not.
            frame_start <= pix_en && (h_next == '0) && (v_next == '0);
        end
    end

`ifdef VGA_SYNC_ALIGN_EN
    // Extra sync stage to match the renderer's one-clk RGB register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            hSync <= 1'b1;
            vSync <= 1'b1;
        end else begin
            hSync <= h_sync_dec;
            vSync <= v_sync_dec;
        end
    end
`else
    assign hSync = h_sync_dec;
    assign vSync = v_sync_dec;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: a default-timing instance (A) and a
// shrunken-timing CLK_DIV=1 instance (B) so whole frames fit in a short run.
// Expected values come from constant tables, hand-derived tallies, and a model
// that computes outputs arithmetically from the clk count since reset release.
module tb_vga_timing_gen;

    typedef struct packed {
        logic       pix_en;
        logic [9:0] h;
        logic [9:0] v;
        logic       bright;
        logic       hs;
        logic       vs;
        logic       vblank;
        logic       fs;
    } obs_t;

    typedef struct {
        int d;
        int hv, hfp, hsy, hbp;
        int vv, vfp, vsy, vbp;
    } tim_t;

    typedef struct {
        int   k;
        obs_t exp;
    } vec_t;

    localparam obs_t RESET_OBS = '{pix_en: 1'b0, h: 10'd0, v: 10'd0, bright: 1'b0,
                                   hs: 1'b1, vs: 1'b1, vblank: 1'b0, fs: 1'b0};

`ifdef VGA_SYNC_ALIGN_EN
    localparam int SYNC_LAG = 1;
`else
    localparam int SYNC_LAG = 0;
`endif

    logic clk = 1'b0;
    logic rst_a, rst_b;
    int   k_a, k_b;
    int   total = 0;
    int   bad   = 0;

    logic       pix_a, br_a, hs_a, vs_a, vb_a, fs_a;
    logic [9:0] h_a, v_a;
    logic       pix_b, br_b, hs_b, vs_b, vb_b, fs_b;
    logic [9:0] h_b, v_b;

    tim_t tim_a = '{d: 2, hv: 640, hfp: 16, hsy: 96, hbp: 48, vv: 480, vfp: 10, vsy: 2, vbp: 33};
    tim_t tim_b = '{d: 1, hv: 16,  hfp: 2,  hsy: 4,  hbp: 3,  vv: 6,   vfp: 2,  vsy: 2, vbp: 2};

    always #5 clk = ~clk;

    vga_timing_gen dut_a (
        .clk(clk), .reset(rst_a), .pix_en(pix_a), .hCount(h_a), .vCount(v_a),
        .bright(br_a), .hSync(hs_a), .vSync(vs_a), .vblank(vb_a), .frame_start(fs_a)
    );

    vga_timing_gen #(
        .CLK_DIV(1), .H_VISIBLE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
        .V_VISIBLE(6), .V_FP(2), .V_SYNC(2), .V_BP(2)
    ) dut_b (
        .clk(clk), .reset(rst_b), .pix_en(pix_b), .hCount(h_b), .vCount(v_b),
        .bright(br_b), .hSync(hs_b), .vSync(vs_b), .vblank(vb_b), .frame_start(fs_b)
    );

    function automatic obs_t obs_a();
        return '{pix_en: pix_a, h: h_a, v: v_a, bright: br_a, hs: hs_a, vs: vs_a, vblank: vb_a, fs: fs_a};
    endfunction

    function automatic obs_t obs_b();
        return '{pix_en: pix_b, h: h_b, v: v_b, bright: br_b, hs: hs_b, vs: vs_b, vblank: vb_b, fs: fs_b};
    endfunction

    // Outputs k clks after reset release, from pixel index n = floor((k-1)/d).
    function automatic obs_t raw_model(int k, tim_t t);
        obs_t o;
        int ht, vt, n, h, v;
        o = RESET_OBS;
        if (k > 0) begin
            ht = t.hv + t.hfp + t.hsy + t.hbp;
            vt = t.vv + t.vfp + t.vsy + t.vbp;
            n  = (k - 1) / t.d;
            h  = n % ht;
            v  = (n / ht) % vt;
            o.pix_en = (k % t.d) == 0;
            o.h      = 10'(h);
            o.v      = 10'(v);
            o.bright = (h < t.hv) && (v < t.vv);
            o.hs     = !((h >= t.hv + t.hfp) && (h < t.hv + t.hfp + t.hsy));
            o.vs     = !((v >= t.vv + t.vfp) && (v < t.vv + t.vfp + t.vsy));
            o.vblank = v >= t.vv;
            o.fs     = ((k - 1) % t.d == 0) && (n > 0) && (n % (ht * vt) == 0);
        end
        return o;
    endfunction

    function automatic obs_t model(int k, tim_t t);
        obs_t o, p;
        o = raw_model(k, t);
        p = raw_model(k - SYNC_LAG, t);
        o.hs = p.hs;
        o.vs = p.vs;
        return o;
    endfunction

    task automatic check(input string name, input int k, input obs_t got, input obs_t want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s k=%0d got pix=%b h=%0d v=%0d br=%b hs=%b vs=%b vb=%b fs=%b want pix=%b h=%0d v=%0d br=%b hs=%b vs=%b vb=%b fs=%b",
                     name, k, got.pix_en, got.h, got.v, got.bright, got.hs, got.vs, got.vblank, got.fs,
                     want.pix_en, want.h, want.v, want.bright, want.hs, want.vs, want.vblank, want.fs);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    // Advance one clk; track clks since release for each instance.
    task automatic tick();
        @(posedge clk);
        k_a = rst_a ? k_a + 1 : 0;
        k_b = rst_b ? k_b + 1 : 0;
        @(negedge clk);
    endtask

    function automatic obs_t mk(logic pe, int h, int v, logic br, logic hs, logic vs, logic vb, logic fs);
        return '{pix_en: pe, h: 10'(h), v: 10'(v), bright: br, hs: hs, vs: vs, vblank: vb, fs: fs};
    endfunction

    vec_t vecs[$];

    initial begin
        int hs_low, br_high, first_low, max_h;
        int fs_cnt, fs_first, vs_low, vb_high, pe_zero;
        int rem_a, rem_b;
        logic hs656, hs752;

        rst_a = 1'b0;
        rst_b = 1'b0;
        k_a   = 0;
        k_b   = 0;
        hs656 = (SYNC_LAG == 0) ? 1'b0 : 1'b1;
        hs752 = (SYNC_LAG == 0) ? 1'b1 : 1'b0;

        // Instance A checkpoints after release: {k, pix, h, v, bright, hs, vs, vblank, fs}.
        vecs.push_back('{0,    mk(0, 0,   0, 0, 1, 1, 0, 0)});
        vecs.push_back('{1,    mk(0, 0,   0, 1, 1, 1, 0, 0)});
        vecs.push_back('{2,    mk(1, 0,   0, 1, 1, 1, 0, 0)});
        vecs.push_back('{3,    mk(0, 1,   0, 1, 1, 1, 0, 0)});
        vecs.push_back('{4,    mk(1, 1,   0, 1, 1, 1, 0, 0)});
        vecs.push_back('{1280, mk(1, 639, 0, 1, 1, 1, 0, 0)});
        vecs.push_back('{1281, mk(0, 640, 0, 0, 1, 1, 0, 0)});
        vecs.push_back('{1312, mk(1, 655, 0, 0, 1, 1, 0, 0)});
        vecs.push_back('{1313, mk(0, 656, 0, 0, hs656, 1, 0, 0)});
        vecs.push_back('{1504, mk(1, 751, 0, 0, 0, 1, 0, 0)});
        vecs.push_back('{1505, mk(0, 752, 0, 0, hs752, 1, 0, 0)});
        vecs.push_back('{1600, mk(1, 799, 0, 0, 1, 1, 0, 0)});
        vecs.push_back('{1601, mk(0, 0,   1, 1, 1, 1, 0, 0)});

        // Reset held 5 clks, then walk the checkpoint table.
        repeat (5) tick();
        check("reset_hold", k_a, obs_a(), vecs[0].exp);
        rst_a = 1'b1;
        for (int i = 1; i < vecs.size(); i++) begin
            while (k_a < vecs[i].k) tick();
            check("vec_a", k_a, obs_a(), vecs[i].exp);
        end

        // One full line on A: sync width, visible width, counter range.
        rst_a = 1'b0;
        tick();
        rst_a = 1'b1;
        hs_low = 0; br_high = 0; first_low = -1; max_h = 0;
        repeat (1600) begin
            tick();
            if (!hs_a) begin
                hs_low++;
                if (first_low < 0) first_low = k_a;
            end
            if (br_a) br_high++;
            if (int'(h_a) > max_h) max_h = int'(h_a);
        end
        check_int("line_hsync_low_clks", hs_low, 192);
        check_int("line_bright_clks", br_high, 1280);
        check_int("line_hsync_first_low_k", first_low, 1313 + SYNC_LAG);
        check_int("line_max_h", max_h, 799);

        // Mid-line reset on A while hSync is low at hCount=700.
        rst_a = 1'b0;
        tick();
        rst_a = 1'b1;
        while (k_a < 1401) tick();
        check("midline_pre", k_a, obs_a(), model(k_a, tim_a));
        rst_a = 1'b0;
        tick();
        check("midline_reset", k_a, obs_a(), RESET_OBS);
        rst_a = 1'b1;
        repeat (6) begin
            tick();
            check("midline_restart", k_a, obs_a(), model(k_a, tim_a));
        end

        // Two full frames on B (CLK_DIV=1, 25x12 raster, 300 clks/frame).
        rst_b = 1'b0;
        tick();
        rst_b = 1'b1;
        fs_cnt = 0; fs_first = -1; vs_low = 0; vb_high = 0; pe_zero = 0;
        repeat (605) begin
            tick();
            check("frame_b", k_b, obs_b(), model(k_b, tim_b));
            if (fs_b) begin
                fs_cnt++;
                if (fs_first < 0) fs_first = k_b;
            end
            if (k_b <= 300 && !vs_b) vs_low++;
            if (k_b <= 300 && vb_b) vb_high++;
            if (!pix_b) pe_zero++;
        end
        check_int("frame_start_pulses", fs_cnt, 2);
        check_int("frame_start_first_k", fs_first, 301);
        check_int("frame_vsync_low_clks", vs_low, 50);
        check_int("frame_vblank_clks", vb_high, 150);
        check_int("div1_pix_en_zero_clks", pe_zero, 0);

        // Mid-frame reset on B with both syncs low (line 8, column 19).
        rst_b = 1'b0;
        tick();
        rst_b = 1'b1;
        while (k_b < 220) tick();
        check("midframe_pre", k_b, obs_b(), model(k_b, tim_b));
        rst_b = 1'b0;
        tick();
        check("midframe_reset", k_b, obs_b(), RESET_OBS);
        rst_b = 1'b1;
        repeat (10) begin
            tick();
            check("midframe_restart", k_b, obs_b(), model(k_b, tim_b));
        end

        // Random reset pulses on both instances, every clk compared with the model.
        rem_a = 0;
        rem_b = 0;
        repeat (4000) begin
            if (rem_a == 0 && $urandom_range(0, 299) == 0) rem_a = int'($urandom_range(1, 4));
            if (rem_b == 0 && $urandom_range(0, 149) == 0) rem_b = int'($urandom_range(1, 4));
            rst_a = (rem_a == 0);
            rst_b = (rem_b == 0);
            if (rem_a > 0) rem_a--;
            if (rem_b > 0) rem_b--;
            tick();
            check("rand_a", k_a, obs_a(), model(k_a, tim_a));
            check("rand_b", k_b, obs_b(), model(k_b, tim_b));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
